// File: rtl/mem_line_responder.sv
// Fixed-latency line store behind the cache line interface: serves full-line
// reads and writebacks with a one-cycle mem_ready pulse per transaction.
module mem_line_responder #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned LINE_W     = 128,
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    logic [DEPTH_LOG2-1:0]   addr_q;
    logic                    wr_q;
    logic [LINE_W-1:0]       wdata_q;

    logic [LINE_W-1:0]       mem_array [DEPTH];

    logic                    req_ok;
    logic                    req_bad;
    logic                    capture;
    logic                    enter_resp;
    logic                    acc_wr;
    logic [DEPTH_LOG2-1:0]   acc_addr;
    logic [LINE_W-1:0]       acc_wdata;
    logic                    ready_d;
    logic                    rd_en;
    logic                    wr_en;
    logic                    err_set;

    // Upper address bits alias onto the same lines.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, mem_addr[ADDR_W-1:DEPTH_LOG2]};

    assign req_ok  = mem_read ^ mem_write;
    assign req_bad = mem_read & mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the RESP entry edge is the sampling edge, so the access
    // must come straight from the request pins instead of the capture regs.
    always_comb begin
        capture    = 1'b0;
        enter_resp = 1'b0;
        acc_wr     = wr_q;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        ready_d    = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        err_set    = 1'b0;
        if (state_q == IDLE) begin
            capture   = req_ok;
            err_set   = req_bad;
            acc_wr    = mem_write;
            acc_addr  = mem_addr[DEPTH_LOG2-1:0];
            acc_wdata = mem_wdata;
        end
        enter_resp = (state_d == RESP) && (state_q != RESP);
        ready_d    = (state_d == RESP);
        rd_en      = enter_resp && !acc_wr;
        wr_en      = enter_resp && acc_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            if (capture) begin
                addr_q  <= mem_addr[DEPTH_LOG2-1:0];
                wr_q    <= mem_write;
                wdata_q <= mem_wdata;
            end
            mem_ready <= ready_d;
            if (rd_en) begin
                mem_rdata <= mem_array[acc_addr];
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Line array is deliberately not reset; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[acc_addr] <= acc_wdata;
        end
    end

endmodule
